// File: rtl/pipe_pkg.sv
// Shared types and default widths for the generic pipeline stage register.
package pipe_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int INFO_W  = 161;
  localparam int W_FD    = PC_W + INSTR_W + INFO_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register plus valid bit; clear beats load and optionally zeroes the payload.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int W            = W_FD,
  parameter int ZERO_ON_KILL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] payload
);

  // Entry storage with kill-to-zero so bubbles carry no stale commit info.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= {W{1'b0}};
    end else if (clear) begin
      valid <= 1'b0;
      if (ZERO_ON_KILL != 0) begin
        payload <= {W{1'b0}};
      end
    end else if (load) begin
      valid   <= 1'b1;
      payload <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/allow_in handshake, stall, flush, optional
// 2-entry skid buffer and a saturating bubble-cycle counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int W            = W_FD,
  parameter int SKID         = 0,
  parameter int ZERO_ON_KILL = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [W-1:0]     up_payload,
  output logic             up_allow_in,
  input  logic             ready_go,
  input  logic             stall,
  input  logic             flush,
  input  logic             down_allow_in,
  output logic             down_valid,
  output logic [W-1:0]     down_payload,
  output logic             head_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  stage_state_e state;
  stage_state_e state_nxt;

  logic         main_valid;
  logic [W-1:0] main_payload;
  logic         skid_valid;
  logic [W-1:0] skid_payload;

  logic         main_load;
  logic         main_clear;
  logic [W-1:0] main_din;
  logic         skid_load;
  logic         skid_clear;

  logic         drain_ok;
  logic         enq;
  logic         deq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  assign drain_ok     = ready_go && !stall;
  assign down_valid   = main_valid && drain_ok;
  assign deq          = down_valid && down_allow_in;
  assign enq          = up_valid && up_allow_in && !flush;
  assign head_valid   = main_valid;
  assign down_payload = main_payload;

  pipe_skid_entry #(
    .W            (W),
    .ZERO_ON_KILL (ZERO_ON_KILL)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_din),
    .valid     (main_valid),
    .payload   (main_payload)
  );

  generate
    if (SKID != 0) begin : g_skid
      // Skid-mode acceptance depends only on a flop, cutting downstream-to-upstream paths.
      assign up_allow_in = !skid_valid;

      pipe_skid_entry #(
        .W            (W),
        .ZERO_ON_KILL (ZERO_ON_KILL)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (up_payload),
        .valid     (skid_valid),
        .payload   (skid_payload)
      );
    end else begin : g_single
      logic unused_skid;
      assign up_allow_in  = !main_valid || (drain_ok && down_allow_in);
      assign skid_valid   = 1'b0;
      assign skid_payload = {W{1'b0}};
      assign unused_skid  = skid_load | skid_clear | skid_valid;
    end
  endgenerate

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and entry load/clear decode; flush overrides every transition.
  always_comb begin
    state_nxt  = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_din   = up_payload;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (enq) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (enq && deq) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end else if (enq) begin
            if (SKID != 0) begin
              state_nxt = TWO;
              skid_load = 1'b1;
            end else begin
              state_nxt = ONE;
              main_load = 1'b1;
            end
          end else if (deq) begin
            state_nxt  = EMPTY;
            main_clear = 1'b1;
          end else begin
            state_nxt = ONE;
          end
        end
        TWO: begin
          if (deq) begin
            state_nxt  = ONE;
            main_load  = 1'b1;
            main_din   = skid_payload;
            skid_clear = 1'b1;
          end else begin
            state_nxt = TWO;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Bubble counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (down_allow_in && !down_valid) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench: DUT0 SKID=0, DUT1 SKID=1, DUT2 SKID=0 with a 4-bit bubble counter.
module tb_pipe_stage;

  logic clk;
  logic rst;

  logic [2:0]       up_valid;
  logic [2:0][15:0] up_payload;
  logic [2:0]       up_allow_in;
  logic [2:0]       ready_go;
  logic [2:0]       stall;
  logic [2:0]       flush;
  logic [2:0]       down_allow_in;
  logic [2:0]       down_valid;
  logic [2:0][15:0] down_payload;
  logic [2:0]       head_valid;
  logic [2:0][31:0] bcnt;

  int n_cmp;
  int n_err;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 32;
    logic [CW-1:0] cnt;
    pipe_stage #(
      .W            (16),
      .SKID         ((g == 1) ? 1 : 0),
      .ZERO_ON_KILL (1),
      .CNT_W        (CW)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .up_valid      (up_valid[g]),
      .up_payload    (up_payload[g]),
      .up_allow_in   (up_allow_in[g]),
      .ready_go      (ready_go[g]),
      .stall         (stall[g]),
      .flush         (flush[g]),
      .down_allow_in (down_allow_in[g]),
      .down_valid    (down_valid[g]),
      .down_payload  (down_payload[g]),
      .head_valid    (head_valid[g]),
      .bubble_cnt    (cnt)
    );
    assign bcnt[g] = 32'(cnt);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on downstream transfer, then model flush or upstream transfer.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst) begin
      if (down_valid[0] && down_allow_in[0]) begin
        exp = (q0.size() > 0) ? 32'(q0.pop_front()) : 32'hDEAD_BEEF;
        check_eq("sb0_payload", 32'(down_payload[0]), exp);
      end
      if (flush[0]) q0.delete();
      else if (up_valid[0] && up_allow_in[0]) q0.push_back(up_payload[0]);
      if (down_valid[1] && down_allow_in[1]) begin
        exp = (q1.size() > 0) ? 32'(q1.pop_front()) : 32'hDEAD_BEEF;
        check_eq("sb1_payload", 32'(down_payload[1]), exp);
      end
      if (flush[1]) q1.delete();
      else if (up_valid[1] && up_allow_in[1]) q1.push_back(up_payload[1]);
    end
  end

  task automatic drive(input int i, input logic uv, input logic [15:0] p, input logic st,
                       input logic fl, input logic dai);
    up_valid[i]      = uv;
    up_payload[i]    = p;
    stall[i]         = st;
    flush[i]         = fl;
    down_allow_in[i] = dai;
    ready_go[i]      = 1'b1;
  endtask

  task automatic cyc(input string tag, input int i, input logic uv, input logic [15:0] p,
                     input logic st, input logic fl, input logic dai, input logic ea,
                     input logic edv, input logic [15:0] epay, input logic ehv);
    drive(i, uv, p, st, fl, dai);
    @(negedge clk);
    check_eq({tag, "/allow_in"}, 32'(up_allow_in[i]), 32'(ea));
    check_eq({tag, "/down_valid"}, 32'(down_valid[i]), 32'(edv));
    check_eq({tag, "/down_payload"}, 32'(down_payload[i]), 32'(epay));
    check_eq({tag, "/head_valid"}, 32'(head_valid[i]), 32'(ehv));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int i, input int n, input logic [15:0] base);
    logic [31:0] b0;
    b0 = bcnt[i];
    for (int k = 0; k <= n; k++) begin
      drive(i, (k < n), base + 16'(k), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (k > 0) begin
        check_eq("stream_valid", 32'(down_valid[i]), 32'd1);
        check_eq("stream_payload", 32'(down_payload[i]), 32'(base + 16'(k - 1)));
      end
      @(posedge clk); #1;
    end
    drive(i, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("stream_bubbles", bcnt[i], b0 + 32'd1);
    check_eq("stream_zeroed", 32'(down_payload[i]), 32'd0);
    check_eq("stream_empty", 32'(head_valid[i]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    #3;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_down_valid", 32'(down_valid[i]), 32'd0);
      check_eq("rst_allow_in", 32'(up_allow_in[i]), 32'd1);
      check_eq("rst_head_valid", 32'(head_valid[i]), 32'd0);
      check_eq("rst_bubble", bcnt[i], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    stream(0, 8, 16'd1);
    stream(1, 8, 16'd1);

    // Backpressure into the skid entry, then in-order release.
    cyc("bp_a", 1, 1'b1, 16'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("bp_b", 1, 1'b1, 16'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5, 1'b1);
    cyc("bp_c", 1, 1'b1, 16'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1);
    cyc("bp_d", 1, 1'b1, 16'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5, 1'b1);
    cyc("bp_e", 1, 1'b1, 16'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h6, 1'b1);
    cyc("bp_f", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7, 1'b1);
    cyc("bp_g", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Stall in single-entry mode blocks acceptance.
    cyc("st0_a", 0, 1'b1, 16'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("st0_b", 0, 1'b1, 16'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAA, 1'b1);
    cyc("st0_c", 0, 1'b1, 16'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAA, 1'b1);
    cyc("st0_d", 0, 1'b1, 16'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hAA, 1'b1);
    cyc("st0_e", 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBB, 1'b1);
    cyc("st0_f", 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Stall in skid mode still lets an item enter the free skid slot.
    cyc("st1_a", 1, 1'b1, 16'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("st1_b", 1, 1'b1, 16'h67, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h66, 1'b1);
    cyc("st1_c", 1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h66, 1'b1);
    cyc("st1_d", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h66, 1'b1);
    cyc("st1_e", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h67, 1'b1);
    cyc("st1_f", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Flush with both entries full and an item offered.
    cyc("fl2_a", 1, 1'b1, 16'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("fl2_b", 1, 1'b1, 16'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h11, 1'b1);
    cyc("fl2_c", 1, 1'b1, 16'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h11, 1'b1);
    cyc("fl2_d", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("fl2_e", 1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check_eq("fl2_queue", 32'(q1.size()), 32'd0);

    // Flush coinciding with a downstream transfer; the offered item is dropped.
    cyc("fld_a", 0, 1'b1, 16'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("fld_b", 0, 1'b1, 16'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h44, 1'b1);
    cyc("fld_c", 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc("fld_d", 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check_eq("fld_queue", 32'(q0.size()), 32'd0);

    // Bubble counter saturation on the 4-bit instance.
    drive(2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) check_eq("sat_mid", bcnt[2], 32'd10);
      @(posedge clk); #1;
    end
    drive(2, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("sat_top", bcnt[2], 32'd15);
    @(posedge clk); #1;
    drive(2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("sat_after_flush", bcnt[2], 32'd15);
    @(posedge clk); #1;

    // Asynchronous reset while an item is being offered downstream.
    cyc("mr_a", 0, 1'b1, 16'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("mr_pre_valid", 32'(down_valid[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_down_valid", 32'(down_valid[0]), 32'd0);
    check_eq("mr_allow_in", 32'(up_allow_in[0]), 32'd1);
    check_eq("mr_payload", 32'(down_payload[0]), 32'd0);
    check_eq("mr_head_valid", 32'(head_valid[0]), 32'd0);
    check_eq("mr_bubble0", bcnt[0], 32'd0);
    check_eq("mr_bubble2", bcnt[2], 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("mr_post", 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
